// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: zero-wait APB UART with TX/RX FIFOs,
// runtime baud divider, sticky error flags and irq.
module apb_uart_fifo #(
  parameter int          BUS_WIDTH = 16,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           S_PADDR,
  input  logic                 S_PWRITE,
  input  logic                 S_PSELx,
  input  logic                 S_PENABLE,
  input  logic [BUS_WIDTH-1:0] S_PWDATA,
  output logic [BUS_WIDTH-1:0] S_PRDATA,
  output logic                 S_PREADY,
  output logic                 tx_wire,
  input  logic                 rx_wire,
  output logic                 irq
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [TAW:0] TX_N = (TAW+1)'(TX_DEPTH);
  localparam logic [RAW:0] RX_N = (RAW+1)'(RX_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;

  logic acc, wr, rd;
  logic a_data, a_stat, a_div, a_ctrl;
  logic [15:0] div_q;
  logic [2:0] ctrl_q;
  logic rx_ovr, frame_err, tx_ovf;
  logic irq_q;
  logic unused_pw;

  logic [7:0] tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TAW:0] tx_lvl;
  logic tx_empty, tx_full, tx_wreq;
  logic tx_push, tx_pop, tx_flush;
  logic [7:0] tx_head;

  st_t tx_st, tx_nx;
  logic [15:0] tx_tick, tx_div;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic tx_q, tx_last, tx_busy;

  logic [7:0] rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RAW:0] rx_lvl;
  logic rx_empty, rx_full;
  logic rx_push, rx_pop, rx_flush;

  logic rx_line, rx_s1, rx_s2, rx_s3, rx_fall;
  st_t rx_st, rx_nx;
  logic [15:0] rx_tick, rx_div;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic rx_last, rx_mid, rx_done, rx_bad;

  assign acc = S_PSELx & S_PENABLE;
  assign wr = acc & S_PWRITE;
  assign rd = acc & ~S_PWRITE;
  assign a_data = S_PADDR == 2'd0;
  assign a_stat = S_PADDR == 2'd1;
  assign a_div = S_PADDR == 2'd2;
  assign a_ctrl = S_PADDR == 2'd3;
  assign unused_pw = ^S_PWDATA;

  assign S_PREADY = 1'b1;
  assign tx_wire = tx_q;
  assign irq = irq_q;

  // divider and control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= DIV_RESET;
      ctrl_q <= 3'd0;
    end else if (wr) begin
      if (a_div)
        div_q <= (S_PWDATA[15:0] < 16'd4) ?
                 16'd4 : S_PWDATA[15:0];
      if (a_ctrl)
        ctrl_q <= S_PWDATA[2:0];
    end
  end

  assign tx_flush = wr & a_ctrl & S_PWDATA[3];
  assign rx_flush = wr & a_ctrl & S_PWDATA[4];

  // ---------------- TX FIFO ----------------
  assign tx_empty = tx_lvl == '0;
  assign tx_full = tx_lvl == TX_N;
  assign tx_head = tx_mem[tx_rp];
  assign tx_wreq = wr & a_data;
  assign tx_push = tx_wreq & (~tx_full | tx_pop);

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wp] <= S_PWDATA[7:0];
  end

  // TX FIFO pointers and fill level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_lvl <= '0;
    end else if (tx_flush) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_lvl <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
      unique case ({tx_push, tx_pop})
        2'b10: tx_lvl <= tx_lvl + 1'b1;
        2'b01: tx_lvl <= tx_lvl - 1'b1;
        default: tx_lvl <= tx_lvl;
      endcase
    end
  end

  // ---------------- TX engine ----------------
  assign tx_last = tx_tick == tx_div - 16'd1;
  assign tx_busy = tx_st != S_IDLE;

  // TX state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tx_st <= S_IDLE;
    else tx_st <= tx_nx;
  end

  // TX next state; pop on frame start
  always_comb begin
    tx_nx = tx_st;
    tx_pop = 1'b0;
    unique case (tx_st)
      S_IDLE:
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_nx = S_START;
        end
      S_START:
        if (tx_last) tx_nx = S_DATA;
      S_DATA:
        if (tx_last && tx_bit == 3'd7)
          tx_nx = S_STOP;
      S_STOP:
        if (tx_last) begin
          if (!tx_empty) begin
            tx_pop = 1'b1;
            tx_nx = S_START;
          end else begin
            tx_nx = S_IDLE;
          end
        end
      default: tx_nx = S_IDLE;
    endcase
  end

  // TX bit timer, shifter and line driver
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_tick <= 16'd0;
      tx_bit <= 3'd0;
      tx_sh <= 8'd0;
      tx_div <= DIV_RESET;
      tx_q <= 1'b1;
    end else if (tx_pop) begin
      tx_sh <= tx_head;
      tx_div <= div_q;
      tx_tick <= 16'd0;
      tx_bit <= 3'd0;
      tx_q <= 1'b0;
    end else begin
      unique case (tx_st)
        S_IDLE: tx_q <= 1'b1;
        S_START:
          if (tx_last) begin
            tx_tick <= 16'd0;
            tx_q <= tx_sh[0];
          end else begin
            tx_tick <= tx_tick + 16'd1;
          end
        S_DATA:
          if (tx_last) begin
            tx_tick <= 16'd0;
            tx_bit <= tx_bit + 3'd1;
            tx_sh <= {1'b0, tx_sh[7:1]};
            tx_q <= (tx_bit == 3'd7) ?
                    1'b1 : tx_sh[1];
          end else begin
            tx_tick <= tx_tick + 16'd1;
          end
        S_STOP:
          if (tx_last) begin
            tx_tick <= 16'd0;
            tx_q <= 1'b1;
          end else begin
            tx_tick <= tx_tick + 16'd1;
          end
        default: tx_q <= 1'b1;
      endcase
    end
  end

  // ---------------- RX engine ----------------
  assign rx_line = ctrl_q[2] ? tx_q : rx_wire;
  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_last = rx_tick == rx_div - 16'd1;
  assign rx_mid = rx_tick ==
                  {1'b0, rx_div[15:1]} - 16'd1;

  // two-flop synchroniser plus edge history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_line;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_st <= S_IDLE;
    else rx_st <= rx_nx;
  end

  // RX next state; stop-bit verdict
  always_comb begin
    rx_nx = rx_st;
    rx_done = 1'b0;
    rx_bad = 1'b0;
    unique case (rx_st)
      S_IDLE:
        if (rx_fall) rx_nx = S_START;
      S_START:
        if (rx_mid)
          rx_nx = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:
        if (rx_last && rx_bit == 3'd7)
          rx_nx = S_STOP;
      S_STOP:
        if (rx_last) begin
          rx_nx = S_IDLE;
          rx_done = rx_s2;
          rx_bad = ~rx_s2;
        end
      default: rx_nx = S_IDLE;
    endcase
  end

  // RX bit timer and shifter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_tick <= 16'd0;
      rx_bit <= 3'd0;
      rx_sh <= 8'd0;
      rx_div <= DIV_RESET;
    end else begin
      unique case (rx_st)
        S_IDLE: begin
          rx_tick <= 16'd0;
          rx_bit <= 3'd0;
          rx_div <= div_q;
        end
        S_START:
          rx_tick <= rx_mid ?
                     16'd0 : rx_tick + 16'd1;
        S_DATA:
          if (rx_last) begin
            rx_tick <= 16'd0;
            rx_sh <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_tick <= rx_tick + 16'd1;
          end
        S_STOP:
          rx_tick <= rx_last ?
                     16'd0 : rx_tick + 16'd1;
        default: rx_tick <= 16'd0;
      endcase
    end
  end

  // ---------------- RX FIFO ----------------
  assign rx_empty = rx_lvl == '0;
  assign rx_full = rx_lvl == RX_N;
  assign rx_pop = rd & a_data & ~rx_empty;
  assign rx_push = rx_done & (~rx_full | rx_pop);

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wp] <= rx_sh;
  end

  // RX FIFO pointers and fill level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_lvl <= '0;
    end else if (rx_flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_lvl <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
      unique case ({rx_push, rx_pop})
        2'b10: rx_lvl <= rx_lvl + 1'b1;
        2'b01: rx_lvl <= rx_lvl - 1'b1;
        default: rx_lvl <= rx_lvl;
      endcase
    end
  end

  // sticky error flags; a new event beats a W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_ovr <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (rx_done & rx_full & ~rx_pop)
        rx_ovr <= 1'b1;
      else if (wr & a_stat & S_PWDATA[5])
        rx_ovr <= 1'b0;
      if (rx_bad)
        frame_err <= 1'b1;
      else if (wr & a_stat & S_PWDATA[6])
        frame_err <= 1'b0;
      if (tx_wreq & tx_full & ~tx_pop)
        tx_ovf <= 1'b1;
      else if (wr & a_stat & S_PWDATA[7])
        tx_ovf <= 1'b0;
    end
  end

  // registered interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else irq_q <= (ctrl_q[0] & ~rx_empty)
               | (ctrl_q[1] & tx_empty & ~tx_busy)
               | rx_ovr | frame_err;
  end

  // read mux, zero outside read accesses
  always_comb begin
    S_PRDATA = '0;
    if (rd) begin
      unique case (1'b1)
        a_data:
          S_PRDATA[7:0] = rx_empty ?
                          8'h00 : rx_mem[rx_rp];
        a_stat:
          S_PRDATA[15:0] = {8'(rx_lvl), tx_ovf,
                            frame_err, rx_ovr,
                            tx_busy, tx_full,
                            tx_empty, rx_full,
                            ~rx_empty};
        a_div: S_PRDATA[15:0] = div_q;
        a_ctrl: S_PRDATA[2:0] = ctrl_q;
        default: S_PRDATA = '0;
      endcase
    end
  end

endmodule
